// File: rtl/seg_display_arbiter.sv
// Round-robin owner selection for the shared 8-digit hex display, with a minimum
// dwell per owner and optional urgent preemption by requester 0.
module seg_display_arbiter #(
   parameter int                  NREQ       = 4,
   parameter int                  DWELL_W    = 24,
   parameter logic [DWELL_W-1:0]  DWELL      = 24'd12000000,
   parameter logic [31:0]         IDLE_VALUE = 32'h00000000,
   parameter bit                  URGENT0    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [31:0]          disp_data,
   output logic [NREQ-1:0]      grant,
   output logic                 busy
);

   // state | meaning
   // IDLE  | no owner, IDLE_VALUE shown
   // OWN   | owner requesting, display tracks its word
   // HOLD  | owner dropped req before dwell expiry, display frozen
   typedef enum logic [1:0] {IDLE, OWN, HOLD} state_t;

   localparam int             IW  = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   state_t               state, n_state;
   logic [NREQ-1:0]      n_grant;
   logic [31:0]          n_disp;
   logic [DWELL_W-1:0]   dwell_cnt, n_cnt;
   // rr_last doubles as the owner index whenever grant is non-zero
   logic [IW-1:0]        rr_last, n_rr;
   logic [31:0]          words [NREQ];
   logic                 pick_valid;
   logic [IW-1:0]        pick, scan;
   logic [IW:0]          scan_sum;

   always_comb begin
      for (int i = 0; i < NREQ; i++) words[i] = req_data[32*i +: 32];
   end

   // Scan from the farthest offset down so the nearest requester after rr_last wins.
   always_comb begin
      pick_valid = 1'b0;
      pick       = rr_last;
      scan_sum   = '0;
      scan       = '0;
      for (int off = NREQ; off >= 1; off--) begin
         scan_sum = {1'b0, rr_last} + (IW+1)'(off);
         if (scan_sum >= (IW+1)'(NREQ)) scan_sum = scan_sum - (IW+1)'(NREQ);
         scan = scan_sum[IW-1:0];
         if (req[scan]) begin
            pick_valid = 1'b1;
            pick       = scan;
         end
      end
   end

   always_comb begin
      n_state = state;
      n_grant = grant;
      n_disp  = disp_data;
      n_cnt   = (dwell_cnt != '0) ? dwell_cnt - 1'b1 : '0;
      n_rr    = rr_last;
      case (state)
         IDLE: begin
            n_disp = IDLE_VALUE;
            if (pick_valid) begin
               n_state = OWN;
               n_grant = ONE << pick;
               n_disp  = words[pick];
               n_cnt   = DWELL - 1'b1;
               n_rr    = pick;
            end
         end
         OWN, HOLD: begin
            if (dwell_cnt == '0) begin
               if (!pick_valid) begin
                  n_state = IDLE;
                  n_grant = '0;
                  n_disp  = IDLE_VALUE;
               end else if (pick == rr_last) begin
                  // sole requester keeps the display with the dwell parked at zero
                  n_state = OWN;
                  n_disp  = words[rr_last];
               end else begin
                  n_state = OWN;
                  n_grant = ONE << pick;
                  n_disp  = words[pick];
                  n_cnt   = DWELL - 1'b1;
                  n_rr    = pick;
               end
            end else if (state == OWN) begin
               if (!req[rr_last]) n_state = HOLD;
               else               n_disp  = words[rr_last];
            end else if (req[rr_last]) begin
               n_state = OWN;
            end
         end
         default: begin
            n_state = IDLE;
            n_grant = '0;
            n_disp  = IDLE_VALUE;
            n_cnt   = '0;
         end
      endcase
      if (URGENT0 && req[0] && !grant[0]) begin
         n_state = OWN;
         n_grant = ONE;
         n_disp  = words[0];
         n_cnt   = DWELL - 1'b1;
         n_rr    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         busy      <= 1'b0;
         disp_data <= IDLE_VALUE;
         dwell_cnt <= '0;
         rr_last   <= IW'(NREQ-1);
      end else begin
         state     <= n_state;
         grant     <= n_grant;
         busy      <= |n_grant;
         disp_data <= n_disp;
         dwell_cnt <= n_cnt;
         rr_last   <= n_rr;
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter: three configurations share one stimulus
// stream and are compared against an owner/age reference model every cycle.
module tb_seg_display_arbiter;

   localparam logic [31:0] IDLE_V = 32'hDEAD0000;
   localparam int NU = 3;

   logic         clk;
   logic         rst;
   logic [3:0]   req;
   logic [31:0]  data_w [4];
   logic [127:0] req_data;
   logic [31:0]  disp_o  [NU];
   logic [3:0]   grant_o [NU];
   logic         busy_o  [NU];

   int n_tests = 0;
   int n_fail  = 0;

   assign req_data = {data_w[3], data_w[2], data_w[1], data_w[0]};

   // u0: test-plan config; u1: same with urgent; u2: DWELL=1 with urgent
   seg_display_arbiter #(.NREQ(4), .DWELL_W(24), .DWELL(24'd4), .IDLE_VALUE(IDLE_V), .URGENT0(1'b0)) u0 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .disp_data(disp_o[0]), .grant(grant_o[0]), .busy(busy_o[0]));
   seg_display_arbiter #(.NREQ(4), .DWELL_W(24), .DWELL(24'd4), .IDLE_VALUE(IDLE_V), .URGENT0(1'b1)) u1 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .disp_data(disp_o[1]), .grant(grant_o[1]), .busy(busy_o[1]));
   seg_display_arbiter #(.NREQ(4), .DWELL_W(24), .DWELL(24'd1), .IDLE_VALUE(IDLE_V), .URGENT0(1'b1)) u2 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .disp_data(disp_o[2]), .grant(grant_o[2]), .busy(busy_o[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: owner index (-1 = none), edges elapsed since the grant, hold flag.
   int          dw_p  [NU] = '{4, 4, 1};
   bit          urg_p [NU] = '{1'b0, 1'b1, 1'b1};
   int          m_owner [NU];
   int          m_age   [NU];
   bit          m_hold  [NU];
   int          m_rr    [NU];
   logic [31:0] m_disp  [NU];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int off = 1; off <= 4; off++) begin
         if (r[(last + off) % 4]) return (last + off) % 4;
      end
      return -1;
   endfunction

   task automatic give(input int u, input int j);
      m_owner[u] = j;
      m_rr[u]    = j;
      m_age[u]   = 0;
      m_hold[u]  = 1'b0;
      m_disp[u]  = data_w[j];
   endtask

   task automatic model_step(input int u);
      int j;
      if (rst) begin
         m_owner[u] = -1; m_age[u] = 0; m_hold[u] = 1'b0; m_rr[u] = 3; m_disp[u] = IDLE_V;
      end else if (urg_p[u] && req[0] && m_owner[u] != 0) begin
         give(u, 0);
      end else if (m_owner[u] < 0) begin
         j = rr_pick(req, m_rr[u]);
         if (j >= 0) give(u, j);
         else m_disp[u] = IDLE_V;
      end else if (m_age[u] >= dw_p[u] - 1) begin
         j = rr_pick(req, m_rr[u]);
         if (j < 0) begin
            m_owner[u] = -1; m_hold[u] = 1'b0; m_disp[u] = IDLE_V;
         end else if (j == m_owner[u]) begin
            m_hold[u] = 1'b0; m_age[u]++; m_disp[u] = data_w[j];
         end else begin
            give(u, j);
         end
      end else begin
         m_age[u]++;
         if (!m_hold[u]) begin
            if (!req[m_owner[u]]) m_hold[u] = 1'b1;
            else m_disp[u] = data_w[m_owner[u]];
         end else if (req[m_owner[u]]) begin
            m_hold[u] = 1'b0;
         end
      end
   endtask

   task automatic drive(input int c);
      rst = 1'b0;
      if (c < 2) begin
         rst = 1'b1; req = 4'b0000;
      end else if (c < 12) begin
         req = 4'b0000;
      end else if (c < 41) begin
         req = 4'b0110;
         data_w[1] = (c >= 20) ? 32'h12345678 : 32'h11111111;
         data_w[2] = 32'h22222222;
      end else if (c < 46) begin
         req = 4'b0000;
      end else if (c == 46) begin
         req = 4'b0010; data_w[1] = 32'h11111111;
      end else if (c < 56) begin
         req = 4'b0000;
      end else if (c == 56) begin
         req = 4'b0100;
      end else if (c < 71) begin
         req = 4'b0101; data_w[0] = 32'h0BAD0BAD;
      end else if (c < 86) begin
         req = 4'b1111;
         rst = (c == 75);
      end else begin
         for (int b = 0; b < 4; b++) if ($urandom_range(5, 0) == 0) req[b] = ~req[b];
         for (int w = 0; w < 4; w++) if ($urandom_range(9, 0) == 0) data_w[w] = $urandom;
         rst = ($urandom_range(149, 0) == 0);
      end
   endtask

   initial begin
      logic [3:0] eg;
      rst = 1'b1;
      req = 4'b0000;
      for (int w = 0; w < 4; w++) data_w[w] = 32'h0;
      for (int u = 0; u < NU; u++) begin
         m_owner[u] = -1; m_age[u] = 0; m_hold[u] = 1'b0; m_rr[u] = 3; m_disp[u] = IDLE_V;
      end
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         for (int u = 0; u < NU; u++) model_step(u);
         @(negedge clk);
         for (int u = 0; u < NU; u++) begin
            eg = (m_owner[u] < 0) ? 4'b0000 : (4'b0001 << m_owner[u]);
            check($sformatf("u%0d c%0d grant", u, c), {28'h0, grant_o[u]}, {28'h0, eg});
            check($sformatf("u%0d c%0d busy", u, c), {31'h0, busy_o[u]}, {31'h0, (m_owner[u] >= 0)});
            check($sformatf("u%0d c%0d disp", u, c), disp_o[u], m_disp[u]);
         end
         drive(c);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
